// File: rtl/world_pkg.sv
// world_pkg: world geometry, probe ordering and sequencer state encodings
package world_pkg;
    localparam int TILE_SHIFT = 4;
    localparam int WORLD_COLS = 40;
    localparam int WORLD_ROWS = 30;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [2:0] {R0, R1, L0, L1, U0, U1, D0, D1} probe_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} probe_state_t;

    function automatic logic [1:0] probe_dir(probe_t p);
        return (p inside {R0, R1}) ? DIR_RIGHT :
               (p inside {L0, L1}) ? DIR_LEFT  :
               (p inside {U0, U1}) ? DIR_UP    : DIR_DOWN;
    endfunction
endpackage

// File: rtl/tile_probe_sequencer_if.sv
// tile_probe_sequencer_if: request/grant port onto the shared world ROM
interface tile_probe_sequencer_if;
    logic        rom_req;
    logic [10:0] rom_addr;
    logic        rom_gnt;
    logic [4:0]  rom_data;

    modport master(output rom_req, rom_addr, input rom_gnt, rom_data);
    modport slave(input rom_req, rom_addr, output rom_gnt, rom_data);
endinterface

// File: rtl/tile_addr_calc.sv
// tile_addr_calc: tile coordinates, bounds and ROM address of one probe point
module tile_addr_calc #(
    parameter int TILE_SHIFT = world_pkg::TILE_SHIFT,
    parameter int WORLD_COLS = world_pkg::WORLD_COLS,
    parameter int WORLD_ROWS = world_pkg::WORLD_ROWS
) (
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  world_pkg::probe_t i_p,
    output logic [6:0]        o_tx,
    output logic [6:0]        o_ty,
    output logic              o_oob,
    output logic [10:0]       o_addr
);
    import world_pkg::*;

    logic [10:0] w_xs;
    logic [10:0] w_ys;

    // Pick the probe pixel just outside the player box edge, then scale to tiles
    always_comb begin
        w_xs = (i_p inside {R0, R1}) ? {1'b0, i_x} + 11'(1 << TILE_SHIFT) :
               (i_p inside {L0, L1}) ? {1'b0, i_x} - 11'd1 :
               (i_p inside {U1, D1}) ? {1'b0, i_x} + 11'((1 << TILE_SHIFT) - 1) :
                                       {1'b0, i_x};
        w_ys = (i_p inside {R1, L1}) ? {1'b0, i_y} + 11'((1 << TILE_SHIFT) - 1) :
               (i_p inside {U0, U1}) ? {1'b0, i_y} - 11'd1 :
               (i_p inside {D0, D1}) ? {1'b0, i_y} + 11'(1 << TILE_SHIFT) :
                                       {1'b0, i_y};
        o_tx   = 7'(w_xs >> TILE_SHIFT);
        o_ty   = 7'(w_ys >> TILE_SHIFT);
        o_oob  = ((i_p inside {L0, L1}) && i_x == 10'd0) ||
                 ((i_p inside {U0, U1}) && i_y == 10'd0) ||
                 (o_tx >= 7'(WORLD_COLS)) || (o_ty >= 7'(WORLD_ROWS));
        o_addr = ({4'b0, o_ty} << 5) + ({4'b0, o_ty} << 3) + {4'b0, o_tx};
    end
endmodule

// File: rtl/tile_probe_sequencer.sv
// tile_probe_sequencer: per-frame eight-point collision probe producing blocked flags
module tile_probe_sequencer #(
    parameter int TILE_SHIFT = world_pkg::TILE_SHIFT,
    parameter int WORLD_COLS = world_pkg::WORLD_COLS,
    parameter int WORLD_ROWS = world_pkg::WORLD_ROWS
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic [9:0]             X_Pos,
    input  logic [9:0]             Y_Pos,
    tile_probe_sequencer_if.master rom,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             blocked
);
    import world_pkg::*;

    probe_state_t r_state;
    probe_state_t w_next;
    probe_t       r_k;
    logic [9:0]   r_x;
    logic [9:0]   r_y;
    logic [3:0]   r_scratch;
    logic [3:0]   r_blocked;
    logic         r_done;
    logic         w_req;
    logic         w_oob;
    logic         w_solid;
    logic [6:0]   w_tx;
    logic [6:0]   w_ty;
    logic [10:0]  w_addr;

    tile_addr_calc #(
        .TILE_SHIFT(TILE_SHIFT),
        .WORLD_COLS(WORLD_COLS),
        .WORLD_ROWS(WORLD_ROWS)
    ) u_addr (
        .i_x(r_x),
        .i_y(r_y),
        .i_p(r_k),
        .o_tx(w_tx),
        .o_ty(w_ty),
        .o_oob(w_oob),
        .o_addr(w_addr)
    );

    assign w_solid      = ~rom.rom_data[0];
    assign rom.rom_req  = w_req;
    assign rom.rom_addr = w_req ? w_addr : '0;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign blocked      = r_blocked;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and ROM request; out-of-bounds probes skip the port entirely
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        case (r_state)
            IDLE:  w_next = frame_start ? ISSUE : IDLE;
            ISSUE: begin
                w_req  = !w_oob;
                w_next = w_oob ? ((r_k == D1) ? DONE : ISSUE) : (rom.rom_gnt ? WAIT : ISSUE);
            end
            WAIT:  w_next = (r_k == D1) ? DONE : ISSUE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pass datapath: latch position, step probes, accumulate then publish flags at once
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= R0;
            r_scratch <= '0;
            r_blocked <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == IDLE && frame_start) begin
                r_x       <= X_Pos;
                r_y       <= Y_Pos;
                r_k       <= R0;
                r_scratch <= '0;
            end else if ((r_state == ISSUE && w_oob) || r_state == WAIT) begin
                r_scratch[probe_dir(r_k)] <= r_scratch[probe_dir(r_k)] | w_oob | (r_state == WAIT && w_solid);
                r_k <= probe_t'(r_k + 3'd1);
            end else if (r_state == DONE) begin
                r_blocked <= r_scratch;
            end
        end
    end
endmodule

// File: tb/tb_tile_probe_sequencer.sv
// tb_tile_probe_sequencer: directed scenarios against hand-computed probe addresses and flags
module tb_tile_probe_sequencer;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       fs = 1'b0;
    logic [9:0] X = '0;
    logic [9:0] Y = '0;
    logic       busy;
    logic       done;
    logic [3:0] blocked;

    tile_probe_sequencer_if rom();

    tile_probe_sequencer dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_start(fs),
        .X_Pos(X),
        .Y_Pos(Y),
        .rom(rom),
        .busy(busy),
        .done(done),
        .blocked(blocked)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int solid_addr = -1;
    int stall_addr = -1;
    int stall_left = 0;
    int stall_seen = 0;
    int leak = 0;
    logic [10:0] seen [16];

    // ROM: sprite 2 (solid) at solid_addr, sprite 1 elsewhere; 0 when no read was granted
    always @(posedge Clk)
        rom.rom_data <= (rom.rom_req && rom.rom_gnt) ?
                        ((int'(rom.rom_addr) == solid_addr) ? 5'd2 : 5'd1) : 5'd0;

    task automatic run_pass(input logic [9:0] px, input logic [9:0] py, output int lat, output int n);
        lat = -1;
        n = 0;
        stall_seen = 0;
        @(negedge Clk);
        X = px;
        Y = py;
        fs = 1'b1;
        @(posedge Clk);
        #1 fs = 1'b0;
        for (int e = 0; e < 80 && lat < 0; e++) begin
            @(negedge Clk);
            if (done) lat = e;
            rom.rom_gnt = 1'b1;
            if (rom.rom_req && int'(rom.rom_addr) == stall_addr && stall_left > 0) begin
                rom.rom_gnt = 1'b0;
                stall_left--;
                stall_seen++;
            end
            if (rom.rom_req && rom.rom_gnt && n < 16) begin
                seen[n] = rom.rom_addr;
                n++;
            end
            if (rom.rom_req && !busy) leak++;
            if (lat < 0) @(posedge Clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        total++;
        if ({rom.rom_req, rom.rom_addr, busy, done, blocked} !== 18'd0) begin
            bad++;
            $display("FAIL reset: req=%b addr=%0d busy=%b done=%b blocked=%b, want all 0",
                     rom.rom_req, rom.rom_addr, busy, done, blocked);
        end
        Reset = 1'b0;
    endtask

    task automatic test_clear_pass;
        int lat, n;
        logic [10:0] exp_a [8] = '{11'd487, 11'd527, 11'd486, 11'd526, 11'd486, 11'd487, 11'd526, 11'd527};
        solid_addr = -1;
        run_pass(10'd100, 10'd200, lat, n);
        total++;
        if (lat !== 17) begin bad++; $display("FAIL clear_latency: got %0d want 17", lat); end
        total++;
        if (n !== 8) begin bad++; $display("FAIL clear_reqs: got %0d want 8", n); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seen[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL clear_addr%0d: got %0d want %0d", i, seen[i], exp_a[i]);
            end
        end
        total++;
        if (blocked !== 4'b0000) begin bad++; $display("FAIL clear_blocked: got %b want 0000", blocked); end
        @(negedge Clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_solid_mix;
        int lat, n;
        solid_addr = 527;
        run_pass(10'd100, 10'd200, lat, n);
        total++;
        if (blocked !== 4'b1001) begin bad++; $display("FAIL mix_blocked: got %b want 1001", blocked); end
        total++;
        if (lat !== 17) begin bad++; $display("FAIL mix_latency: got %0d want 17", lat); end
        solid_addr = -1;
    endtask

    task automatic test_origin;
        int lat, n;
        logic [10:0] exp_a [4] = '{11'd1, 11'd1, 11'd40, 11'd40};
        run_pass(10'd0, 10'd0, lat, n);
        total++;
        if (lat !== 13) begin bad++; $display("FAIL origin_latency: got %0d want 13", lat); end
        total++;
        if (n !== 4) begin bad++; $display("FAIL origin_reqs: got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seen[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL origin_addr%0d: got %0d want %0d", i, seen[i], exp_a[i]);
            end
        end
        total++;
        if (blocked !== 4'b0110) begin bad++; $display("FAIL origin_blocked: got %b want 0110", blocked); end
    endtask

    task automatic test_stall;
        int lat, n;
        stall_addr = 527;
        stall_left = 5;
        run_pass(10'd100, 10'd200, lat, n);
        total++;
        if (stall_seen !== 5) begin bad++; $display("FAIL stall_hold: got %0d stalled cycles at 527 want 5", stall_seen); end
        total++;
        if (lat !== 22) begin bad++; $display("FAIL stall_latency: got %0d want 22", lat); end
        total++;
        if (n !== 8 || seen[1] !== 11'd527) begin
            bad++;
            $display("FAIL stall_reqs: got n=%0d addr1=%0d want 8 527", n, seen[1]);
        end
        total++;
        if (blocked !== 4'b0000) begin bad++; $display("FAIL stall_blocked: got %b want 0000", blocked); end
        stall_addr = -1;
    endtask

    task automatic test_far_corner;
        int lat, n;
        logic [10:0] exp_a [4] = '{11'd1198, 11'd1198, 11'd1159, 11'd1159};
        run_pass(10'd624, 10'd464, lat, n);
        total++;
        if (lat !== 13) begin bad++; $display("FAIL corner_latency: got %0d want 13", lat); end
        total++;
        if (n !== 4) begin bad++; $display("FAIL corner_reqs: got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seen[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL corner_addr%0d: got %0d want %0d", i, seen[i], exp_a[i]);
            end
        end
        total++;
        if (blocked !== 4'b1001) begin bad++; $display("FAIL corner_blocked: got %b want 1001", blocked); end
    endtask

    task automatic test_reset_mid_pass;
        int lat, n, dones;
        dones = 0;
        @(negedge Clk);
        X = 10'd100;
        Y = 10'd200;
        fs = 1'b1;
        @(posedge Clk);
        #1 fs = 1'b0;
        repeat (6) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        total++;
        if ({rom.rom_req, rom.rom_addr, busy, done, blocked} !== 18'd0) begin
            bad++;
            $display("FAIL midreset_outputs: req=%b addr=%0d busy=%b done=%b blocked=%b, want all 0",
                     rom.rom_req, rom.rom_addr, busy, done, blocked);
        end
        @(posedge Clk);
        #1 Reset = 1'b0;
        repeat (30) begin
            @(negedge Clk);
            if (done) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL midreset_nodone: got %0d done pulses want 0", dones); end
        solid_addr = 527;
        run_pass(10'd100, 10'd200, lat, n);
        total++;
        if (lat !== 17 || n !== 8) begin
            bad++;
            $display("FAIL midreset_rerun: latency=%0d reqs=%0d want 17 8", lat, n);
        end
        total++;
        if (blocked !== 4'b1001) begin bad++; $display("FAIL midreset_blocked: got %b want 1001", blocked); end
        solid_addr = -1;
    endtask

    initial begin
        rom.rom_gnt = 1'b1;
        test_reset;
        test_clear_pass;
        test_solid_mix;
        test_origin;
        test_stall;
        test_far_corner;
        test_reset_mid_pass;
        total++;
        if (leak !== 0) begin bad++; $display("FAIL req_while_idle: got %0d cycles want 0", leak); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tile_probe_sequencer.md
# tile_probe_sequencer

Per-frame collision probe controller for the player sprite. On each frame-start pulse it latches the player position. It then sequences up to eight tile lookups against the shared single-port world ROM through a request/grant handshake; the renderer owns the port at higher priority. It publishes four per-direction blocked flags, which the movement logic uses to clamp velocity before the next frame.

## Interface
Parameters:
- TILE_SHIFT, 4, log2 of tile edge in pixels (16×16 tiles, 16×16 player box)
- WORLD_COLS, 40, tiles per row
- WORLD_ROWS, 30, tile rows

Ports:
- Clk  in  1  system clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse, start of a probe pass
- X_Pos  in  10  player top-left X, pixels
- Y_Pos  in  10  player top-left Y, pixels
- rom_gnt  in  1  world ROM port granted to this block this cycle
- rom_data  in  5  tile sprite index; valid the cycle after a granted request
- rom_req  out  1  request for the world ROM port
- rom_addr  out  11  tile address, ty*WORLD_COLS+tx
- busy  out  1  probe pass in progress
- done  out  1  one-cycle pulse; blocked updated in the same cycle
- blocked  out  4  {down, up, left, right}; 1 = solid tile adjacent

## Operation
- Latch X_Pos/Y_Pos as x,y on an accepted frame_start; ignore frame_start while busy.
- Probe order, fixed:
  - R0 (tx=(x+16)>>4, ty=y>>4), R1 (tx=(x+16)>>4, ty=(y+15)>>4)
  - L0 (tx=(x-1)>>4, ty=y>>4), L1 (tx=(x-1)>>4, ty=(y+15)>>4)
  - U0 (tx=x>>4, ty=(y-1)>>4), U1 (tx=(x+15)>>4, ty=(y-1)>>4)
  - D0 (tx=x>>4, ty=(y+16)>>4), D1 (tx=(x+15)>>4, ty=(y+16)>>4)
- Use 11-bit arithmetic for the +16/+15 sums.
- Out of bounds means any of: x==0 for L, y==0 for U, tx≥WORLD_COLS, ty≥WORLD_ROWS. An out-of-bounds probe counts as solid and issues no ROM request.
- Solid tile: rom_data[0]==0 (even sprite index).
- Address: (ty<<5)+(ty<<3)+tx; no multiplier.
- Accumulate results in a 4-bit scratch register, cleared at pass start. Each direction's flag is the OR of its two probes.
- FSM:
  - IDLE: frame_start → ISSUE, probe index k=0, scratch=0.
  - ISSUE: if probe k is out of bounds, set its flag and advance in 1 cycle. Otherwise assert rom_req with rom_addr; on rom_gnt → WAIT. rom_req and rom_addr stay stable until granted.
  - WAIT: sample rom_data and OR in the solid result. If k==7 → DONE, else k+1 → ISSUE.
  - DONE: copy scratch to blocked, pulse done, → IDLE.
- busy=1 in ISSUE, WAIT and DONE.
- blocked holds its previous value through a pass; it never shows partial results.

## Timing
- Reset values: rom_req=0, rom_addr=0, busy=0, done=0, blocked=4'b0000. FSM returns to IDLE.
- Reset mid-pass aborts the pass; there is no done pulse afterwards.
- ROM read latency is 1 cycle after the grant cycle.
- Pass latency:
  - all grants immediate, no out-of-bounds probes: done is high 17 cycles after the edge that samples frame_start (8×2 + 1).
  - each out-of-bounds probe subtracts 1 cycle.
  - each stalled grant cycle adds 1 cycle.
- At most one outstanding request; rom_req never asserts in WAIT, DONE or IDLE.
- frame_start coincident with DONE is ignored; the next pulse starts a new pass.

## Structure
- Package world_pkg holds:
  - WORLD_COLS, WORLD_ROWS, TILE_SHIFT
  - probe_t enum: R0,R1,L0,L1,U0,U1,D0,D1
  - probe_state_t enum: IDLE, ISSUE, WAIT, DONE
  - DIR_RIGHT=0, DIR_LEFT=1, DIR_UP=2, DIR_DOWN=3
- One sub-module, tile_addr_calc. It is combinational: from x, y and the probe index it produces tx, ty, oob and the 11-bit address. It is shared with the renderer's address path.

## Test plan
- X=100, Y=200, tiles all index 1, rom_gnt=1 → rom_addr sequence 487, 527, 486, 526, 486, 487, 526, 527; done 17 cycles after frame_start; blocked=0000.
- Same position; ROM returns 2 at address 527, 1 elsewhere → blocked=1001 (right and down).
- X=0, Y=0, all tiles 1 → no request for L0, L1, U0, U1; blocked=0110; done after 13 cycles.
- X=624, Y=464 → R and D probes out of bounds, no requests for them; blocked includes 1001.
- rom_gnt low for 5 cycles on R1 → rom_req and rom_addr=527 held stable; done delayed to cycle 22.
- Reset pulse at cycle 6 of a pass → all outputs 0 next cycle; no done; previous blocked cleared; a new frame_start runs a full pass.
